// File: rtl/bitblade_accum.sv
// ---------------------------------------------------------------------------
// bitblade_accum
//   Accumulation stage behind the 4-lane 8-bit Bitblade inner-product unit.
//   Each accepted beat carries one unsigned IN_W-bit partial dot product.
//   A configured number of beats is summed into an ACC_W-bit saturating
//   accumulator. The result is then presented to the CFU response path.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   cfg_valid/cfg_ready   start request; cfg_len = number of beats to sum
//   abort                 synchronous cancel, returns to IDLE, drops result
//   in_valid/in_ready     partial-sum stream (in_c)
//   out_valid/out_ready   result handshake (out_acc, out_ovf sticky sat flag)
//   busy                  high while accumulating or holding a result
// ---------------------------------------------------------------------------
module bitblade_accum #(
  parameter int IN_W  = 18,
  parameter int ACC_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_len,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf,
  output logic             busy
);

  localparam int SUM_W = ACC_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_HOLD
  } state_t;

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   remaining;
  logic               ovf;

  logic               cfg_fire;
  logic               in_fire;
  logic               out_fire;
  logic [SUM_W-1:0]   sum;
  logic [ACC_W-1:0]   acc_next;

  // Ready signals depend only on state, out_ready and abort. Gating them
  // with abort makes any handshake in an abort cycle a non-transfer on
  // both sides of the interface.
  assign cfg_ready = !abort && ((state == S_IDLE) ||
                                ((state == S_HOLD) && out_ready));
  assign in_ready  = !abort && (state == S_ACC);

  assign cfg_fire  = cfg_valid && cfg_ready;
  assign in_fire   = in_valid  && in_ready;
  assign out_fire  = out_valid && out_ready;

  // One extra carry bit detects overflow. Once saturated, acc holds its
  // all-ones value, and every later nonzero beat carries out again.
  assign sum      = {1'b0, acc} + SUM_W'(in_c);
  assign acc_next = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];

  // All outputs come straight from flops. They stay stable in HOLD until
  // the consumer takes the result.
  assign out_valid = (state == S_HOLD);
  assign out_acc   = acc;
  assign out_ovf   = ovf;
  assign busy      = (state != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      acc       <= '0;
      remaining <= '0;
      ovf       <= 1'b0;
    end else if (abort) begin
      state     <= S_IDLE;
      acc       <= '0;
      remaining <= '0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cfg_fire) begin
            acc       <= '0;
            ovf       <= 1'b0;
            remaining <= cfg_len;
            state     <= (cfg_len == '0) ? S_HOLD : S_ACC;
          end
        end
        S_ACC: begin
          if (in_fire) begin
            acc       <= acc_next;
            ovf       <= ovf | sum[ACC_W];
            // remaining is at least 1 here, so it never wraps.
            remaining <= remaining - 1'b1;
            if (remaining == CNT_W'(1)) state <= S_HOLD;
          end
        end
        S_HOLD: begin
          // In HOLD, cfg_fire implies out_ready, so the result is
          // consumed on the same edge that starts the next operation.
          if (cfg_fire) begin
            acc       <= '0;
            ovf       <= 1'b0;
            remaining <= cfg_len;
            state     <= (cfg_len == '0) ? S_HOLD : S_ACC;
          end else if (out_fire) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bitblade_accum.sv
// ---------------------------------------------------------------------------
// tb_bitblade_accum
//   Directed testbench for bitblade_accum. It drives two instances from the
//   same inputs:
//     dut   : default ACC_W = 32
//     dut_s : ACC_W = 20, used to exercise saturation
//   Inputs change 1 ns after the rising edge. Outputs are sampled at that
//   same point, well away from the next active edge.
// ---------------------------------------------------------------------------
module tb_bitblade_accum;

  localparam int IN_W  = 18;
  localparam int CNT_W = 16;

  logic              clk;
  logic              rst_n;
  logic              cfg_valid;
  logic [CNT_W-1:0]  cfg_len;
  logic              abort;
  logic              in_valid;
  logic [IN_W-1:0]   in_c;
  logic              out_ready;

  logic              cfg_ready, in_ready, out_valid, out_ovf, busy;
  logic [31:0]       out_acc;
  logic              cfg_ready_s, in_ready_s, out_valid_s, out_ovf_s, busy_s;
  logic [19:0]       out_acc_s;

  int n_cmp = 0;
  int n_err = 0;

  bitblade_accum #(.IN_W(IN_W), .ACC_W(32), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_len   (cfg_len),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_c      (in_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  bitblade_accum #(.IN_W(IN_W), .ACC_W(20), .CNT_W(CNT_W)) dut_s (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready_s),
    .cfg_len   (cfg_len),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_ready  (in_ready_s),
    .in_c      (in_c),
    .out_valid (out_valid_s),
    .out_ready (out_ready),
    .out_acc   (out_acc_s),
    .out_ovf   (out_ovf_s),
    .busy      (busy_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge and land 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One configuration transfer. The caller guarantees cfg_ready is high.
  task automatic cfg_start(input logic [CNT_W-1:0] len);
    cfg_valid = 1'b1;
    cfg_len   = len;
    step();
    cfg_valid = 1'b0;
  endtask

  // One input beat. The caller guarantees the block is in ACC.
  task automatic send_beat(input logic [IN_W-1:0] v);
    in_valid = 1'b1;
    in_c     = v;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0 ||
        out_acc !== 32'd0 || out_ovf !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: valid=%b in_ready=%b busy=%b acc=%0d ovf=%b, want all zero",
               out_valid, in_ready, busy, out_acc, out_ovf);
    end
    n_cmp++;
    if (cfg_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_cfg_ready: got %b want 1", cfg_ready);
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    cfg_start(16'd3);
    n_cmp++;
    if (in_ready !== 1'b1 || busy !== 1'b1 || cfg_ready !== 1'b0) begin
      n_err++;
      $display("FAIL basic_acc_state: in_ready=%b busy=%b cfg_ready=%b want 1 1 0",
               in_ready, busy, cfg_ready);
    end
    send_beat(18'd100);
    send_beat(18'd200);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_early_valid: got %b want 0", out_valid);
    end
    send_beat(18'd262143);
    n_cmp++;
    if (out_valid !== 1'b1 || out_acc !== 32'd262443 || out_ovf !== 1'b0 ||
        in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL basic_result: valid=%b acc=%0d ovf=%b in_ready=%b want 1 262443 0 0",
               out_valid, out_acc, out_ovf, in_ready);
    end
    step();
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
      n_err++;
      $display("FAIL basic_back_idle: valid=%b busy=%b cfg_ready=%b want 0 0 1",
               out_valid, busy, cfg_ready);
    end
  endtask

  // Gapped input and output backpressure, then a back-to-back restart.
  task automatic test_back_to_back();
    out_ready = 1'b0;
    cfg_start(16'd4);
    for (int i = 0; i < 4; i++) begin
      send_beat(18'd5);
      if (i != 3) step();   // gap cycle with in_valid low
    end
    n_cmp++;
    if (out_valid !== 1'b1 || out_acc !== 32'd20 || cfg_ready !== 1'b0) begin
      n_err++;
      $display("FAIL bp_result: valid=%b acc=%0d cfg_ready=%b want 1 20 0",
               out_valid, out_acc, cfg_ready);
    end
    // Stray input and config requests during the stall must be ignored.
    cfg_len   = 16'd1;
    cfg_valid = 1'b1;
    in_valid  = 1'b1;
    in_c      = 18'd99;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (out_valid !== 1'b1 || out_acc !== 32'd20 || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold_%0d: valid=%b acc=%0d in_ready=%b want 1 20 0",
                 i, out_valid, out_acc, in_ready);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (cfg_ready !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_cfg_ready: got %b want 1", cfg_ready);
    end
    step();
    cfg_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_enter_acc: valid=%b in_ready=%b busy=%b want 0 1 1",
               out_valid, in_ready, busy);
    end
    send_beat(18'd7);
    n_cmp++;
    if (out_valid !== 1'b1 || out_acc !== 32'd7 || out_ovf !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_result: valid=%b acc=%0d ovf=%b want 1 7 0",
               out_valid, out_acc, out_ovf);
    end
    step();
  endtask

  task automatic test_saturation();
    out_ready = 1'b1;
    cfg_start(16'd5);
    for (int i = 0; i < 4; i++) send_beat(18'd262143);
    n_cmp++;
    if (out_acc_s !== 20'd1048572 || out_ovf_s !== 1'b0 || in_ready_s !== 1'b1) begin
      n_err++;
      $display("FAIL sat_pre: acc=%0d ovf=%b in_ready=%b want 1048572 0 1",
               out_acc_s, out_ovf_s, in_ready_s);
    end
    send_beat(18'd262143);
    n_cmp++;
    if (out_valid_s !== 1'b1 || out_acc_s !== 20'd1048575 || out_ovf_s !== 1'b1) begin
      n_err++;
      $display("FAIL sat_result: valid=%b acc=%0d ovf=%b want 1 1048575 1",
               out_valid_s, out_acc_s, out_ovf_s);
    end
    n_cmp++;
    if (out_valid !== 1'b1 || out_acc !== 32'd1310715 || out_ovf !== 1'b0) begin
      n_err++;
      $display("FAIL sat_wide: valid=%b acc=%0d ovf=%b want 1 1310715 0",
               out_valid, out_acc, out_ovf);
    end
    step();
    cfg_start(16'd1);
    send_beat(18'd1);
    n_cmp++;
    if (out_valid_s !== 1'b1 || out_acc_s !== 20'd1 || out_ovf_s !== 1'b0) begin
      n_err++;
      $display("FAIL sat_next_op: valid=%b acc=%0d ovf=%b want 1 1 0",
               out_valid_s, out_acc_s, out_ovf_s);
    end
    step();
  endtask

  task automatic test_zero_len_abort();
    out_ready = 1'b1;
    cfg_start(16'd0);
    n_cmp++;
    if (out_valid !== 1'b1 || out_acc !== 32'd0 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL zero_len: valid=%b acc=%0d in_ready=%b want 1 0 0",
               out_valid, out_acc, in_ready);
    end
    step();
    cfg_start(16'd10);
    for (int i = 0; i < 4; i++) send_beat(18'd1);
    abort    = 1'b1;
    in_valid = 1'b1;
    in_c     = 18'd50;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL abort_in_ready: got %b want 0", in_ready);
    end
    step();
    abort    = 1'b0;
    in_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || out_acc !== 32'd0) begin
      n_err++;
      $display("FAIL abort_idle: busy=%b valid=%b acc=%0d want 0 0 0",
               busy, out_valid, out_acc);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL abort_no_valid_%0d: got %b want 0", i, out_valid);
      end
    end
    // Abort also discards a result pending in HOLD.
    out_ready = 1'b0;
    cfg_start(16'd0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL abort_hold: valid=%b busy=%b want 0 0", out_valid, busy);
    end
    out_ready = 1'b1;
    cfg_start(16'd2);
    send_beat(18'd1);
    send_beat(18'd2);
    n_cmp++;
    if (out_valid !== 1'b1 || out_acc !== 32'd3) begin
      n_err++;
      $display("FAIL abort_fresh_op: valid=%b acc=%0d want 1 3", out_valid, out_acc);
    end
    step();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    cfg_start(16'd5);
    send_beat(18'd9);
    send_beat(18'd9);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || out_acc !== 32'd0 ||
        out_valid !== 1'b0 || out_ovf !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: busy=%b in_ready=%b acc=%0d valid=%b ovf=%b want 0 0 0 0 0",
               busy, in_ready, out_acc, out_valid, out_ovf);
    end
    #2;
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_idle: cfg_ready=%b busy=%b want 1 0", cfg_ready, busy);
    end
    cfg_start(16'd1);
    send_beat(18'd4);
    n_cmp++;
    if (out_valid !== 1'b1 || out_acc !== 32'd4) begin
      n_err++;
      $display("FAIL post_reset_op: valid=%b acc=%0d want 1 4", out_valid, out_acc);
    end
    step();
  endtask

  // Upper bound on CNT_W: the largest length must finish without wrapping
  // the beat counter. The beats carry 0, so the expected sum is 0 and the
  // result appears only after exactly 65535 beats.
  task automatic test_max_len();
    out_ready = 1'b1;
    cfg_start(16'hFFFF);
    in_valid = 1'b1;
    in_c     = 18'd0;
    for (int i = 0; i < 65534; i++) step();
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL max_len_pre: valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
    step();
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_acc !== 32'd0) begin
      n_err++;
      $display("FAIL max_len_done: valid=%b acc=%0d want 1 0", out_valid, out_acc);
    end
    step();
  endtask

  initial begin
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    cfg_len   = '0;
    abort     = 1'b0;
    in_valid  = 1'b0;
    in_c      = '0;
    out_ready = 1'b0;
    #3;
    test_reset();
    #10;
    rst_n = 1'b1;
    step();
    test_basic();
    test_back_to_back();
    test_saturation();
    test_zero_len_abort();
    test_async_reset();
    test_max_len();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
